// File: rtl/lisnoc_packet_tx_if.sv
// Link bundle for the packetizer: descriptor and payload input,
// flat valid/ready flit output towards a router input port.
interface lisnoc_packet_tx_if #(
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2,
  parameter int ph_dest_width   = 5,
  parameter int ph_prio_width   = 4,
  parameter int vchannels       = 1,
  parameter int len_width       = 8
);
  localparam int FLIT_WIDTH = flit_data_width + flit_type_width;
  localparam int VC_W = (vchannels > 1) ? $clog2(vchannels) : 1;

  logic                       req_valid;
  logic                       req_ready;
  logic [ph_dest_width-1:0]   req_dest;
  logic [ph_prio_width-1:0]   req_prio;
  logic [VC_W-1:0]            req_vc;
  logic [len_width-1:0]       req_len;
  logic                       data_valid;
  logic                       data_ready;
  logic [flit_data_width-1:0] data_in;
  logic [FLIT_WIDTH-1:0]      out_flit;
  logic [vchannels-1:0]       out_valid;
  logic [vchannels-1:0]       out_ready;
  logic                       busy;

  modport master (
    input  req_valid, req_dest, req_prio,
    input  req_vc, req_len,
    input  data_valid, data_in, out_ready,
    output req_ready, data_ready,
    output out_flit, out_valid, busy
  );

  modport slave (
    output req_valid, req_dest, req_prio,
    output req_vc, req_len,
    output data_valid, data_in, out_ready,
    input  req_ready, data_ready,
    input  out_flit, out_valid, busy
  );
endinterface

// File: rtl/lisnoc_packet_tx.sv
// Packetizer: descriptor + payload words in, typed flits out
// through a single output register on one virtual channel.
module lisnoc_packet_tx #(
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2,
  parameter int ph_dest_width   = 5,
  parameter int ph_prio_width   = 4,
  parameter int ph_prio_offset  = 0,
  parameter int vchannels       = 1,
  parameter int len_width       = 8
) (
  input logic clk,
  input logic rst,
  lisnoc_packet_tx_if.master link
);
  localparam int FLIT_WIDTH = flit_data_width + flit_type_width;
  localparam int VC_W = (vchannels > 1) ? $clog2(vchannels) : 1;

  localparam logic [1:0] T_PAYLOAD = 2'b00;
  localparam logic [1:0] T_HEADER  = 2'b01;
  localparam logic [1:0] T_LAST    = 2'b10;
  localparam logic [1:0] T_SINGLE  = 2'b11;

  typedef enum logic {IDLE, PAYLOAD} state_t;

  state_t                     state, state_n;
  logic [len_width-1:0]       remaining, remaining_n;
  logic                       obuf_valid;
  logic [FLIT_WIDTH-1:0]      obuf_flit, load_flit;
  logic [VC_W-1:0]            obuf_vc, load_vc, vc_map;
  logic [vchannels-1:0]       valid_vec;
  logic [flit_data_width-1:0] hdr;
  logic                       fire, can_load, load;
  logic                       req_ready, data_ready;

  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < vchannels; i++)
      valid_vec[i] = obuf_valid && (VC_W'(i) == obuf_vc);
  end

  // other VCs' ready bits are masked out by the one-hot valid
  assign fire     = |(valid_vec & link.out_ready);
  assign can_load = !obuf_valid || fire;

  always_comb begin
    hdr = '0;
    hdr[flit_data_width-1 -: ph_dest_width] = link.req_dest;
    hdr[ph_prio_offset +: ph_prio_width]    = link.req_prio;
  end

  assign vc_map = (int'(link.req_vc) < vchannels) ?
                  link.req_vc : '0;

  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    load        = 1'b0;
    load_flit   = obuf_flit;
    load_vc     = obuf_vc;
    req_ready   = 1'b0;
    data_ready  = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = can_load && !rst;
        if (link.req_valid && req_ready) begin
          load        = 1'b1;
          load_vc     = vc_map;
          remaining_n = link.req_len;
          if (link.req_len == '0) begin
            load_flit = {T_SINGLE, hdr};
          end else begin
            load_flit = {T_HEADER, hdr};
            state_n   = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        data_ready = can_load && !rst;
        if (link.data_valid && data_ready) begin
          load        = 1'b1;
          remaining_n = remaining - 1'b1;
          if (remaining == len_width'(1)) begin
            load_flit = {T_LAST, link.data_in};
            state_n   = IDLE;
          end else begin
            load_flit = {T_PAYLOAD, link.data_in};
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      remaining  <= '0;
      obuf_valid <= 1'b0;
      obuf_flit  <= '0;
      obuf_vc    <= '0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      if (load) begin
        obuf_valid <= 1'b1;
        obuf_flit  <= load_flit;
        obuf_vc    <= load_vc;
      end else if (fire) begin
        obuf_valid <= 1'b0;
      end
    end
  end

  assign link.req_ready  = req_ready;
  assign link.data_ready = data_ready;
  assign link.out_flit   = obuf_flit;
  assign link.out_valid  = valid_vec;
  assign link.busy       = (state == PAYLOAD) || obuf_valid;
endmodule

// File: tb/tb_lisnoc_packet_tx.sv
// Directed bench for lisnoc_packet_tx: header-only, streaming,
// backpressure, core stall, mid-packet reset and max length.
module tb_lisnoc_packet_tx;
  localparam int FW = 34;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lisnoc_packet_tx_if #(
    .flit_data_width(32), .flit_type_width(2),
    .ph_dest_width(5), .ph_prio_width(4),
    .vchannels(2), .len_width(8)
  ) link ();

  lisnoc_packet_tx #(
    .flit_data_width(32), .flit_type_width(2),
    .ph_dest_width(5), .ph_prio_width(4),
    .ph_prio_offset(0), .vchannels(2),
    .len_width(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .link(link)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int vcnt = 0;
  logic [FW-1:0] fq[$];
  logic [1:0]    vq[$];
  int            cq[$];

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] hf(logic [1:0] t,
      logic [4:0] d, logic [3:0] p);
    return {t, d, 23'd0, p};
  endfunction

  function automatic logic [FW-1:0] pf(logic [1:0] t,
      logic [31:0] w);
    return {t, w};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (link.out_valid != 2'b00) vcnt++;
      if (|(link.out_valid & link.out_ready)) begin
        fq.push_back(link.out_flit);
        vq.push_back(link.out_valid);
        cq.push_back(cyc);
      end
    end
  end

  task automatic clr();
    fq.delete();
    vq.delete();
    cq.delete();
    vcnt = 0;
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_req(logic [4:0] d, logic [3:0] p,
                        logic v, logic [7:0] l);
    int n;
    link.req_dest  = d;
    link.req_prio  = p;
    link.req_vc    = v;
    link.req_len   = l;
    link.req_valid = 1'b1;
    for (n = 0; n < 500; n++) begin
      @(negedge clk);
      if (link.req_ready) break;
    end
    if (n == 500) check("req_timeout", 0, 1);
    @(posedge clk);
    #1 link.req_valid = 1'b0;
  endtask

  task automatic do_data(logic [31:0] w);
    int n;
    link.data_in    = w;
    link.data_valid = 1'b1;
    for (n = 0; n < 500; n++) begin
      @(negedge clk);
      if (link.data_ready) break;
    end
    if (n == 500) check("data_timeout", 0, 1);
    @(posedge clk);
    #1 link.data_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int nl;
    link.req_valid  = 1'b0;
    link.req_dest   = '0;
    link.req_prio   = '0;
    link.req_vc     = '0;
    link.req_len    = '0;
    link.data_valid = 1'b0;
    link.data_in    = '0;
    link.out_ready  = 2'b11;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", link.out_valid, 0);
    check("rst_flit", link.out_flit, 0);
    check("rst_req_rdy", link.req_ready, 0);
    check("rst_dat_rdy", link.data_ready, 0);
    check("rst_busy", link.busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_rdy", link.req_ready, 1);
    tick(1);

    // header-only packet
    clr();
    do_req(5'd5, 4'd3, 1'b0, 8'd0);
    tick(5);
    check("single_cnt", fq.size(), 1);
    check("single_flit", fq[0], {2'b11, 32'h2800_0003});
    check("single_vld", vq[0], 2'b01);
    check("single_vcyc", vcnt, 1);
    check("single_busy", link.busy, 0);

    // streaming plus a queued header-only request
    clr();
    do_req(5'd9, 4'd1, 1'b0, 8'd3);
    do_data(32'hA);
    do_data(32'hB);
    do_data(32'hC);
    do_req(5'd2, 4'd0, 1'b0, 8'd0);
    tick(5);
    check("strm_cnt", fq.size(), 5);
    check("strm_f0", fq[0], hf(2'b01, 5'd9, 4'd1));
    check("strm_f1", fq[1], pf(2'b00, 32'hA));
    check("strm_f2", fq[2], pf(2'b00, 32'hB));
    check("strm_f3", fq[3], pf(2'b10, 32'hC));
    check("strm_f4", fq[4], hf(2'b11, 5'd2, 4'd0));
    for (int i = 1; i < 5; i++)
      check("strm_gap", cq[i] - cq[i-1], 1);

    // backpressure on VC 1; ready of VC 0 must be ignored
    clr();
    link.out_ready = 2'b01;
    do_req(5'd7, 4'd2, 1'b1, 8'd1);
    link.data_in    = 32'h55;
    link.data_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", link.out_valid, 2'b10);
      check("bp_flit", link.out_flit,
            hf(2'b01, 5'd7, 4'd2));
      check("bp_dat_rdy", link.data_ready, 0);
    end
    @(posedge clk);
    #1 link.out_ready = 2'b11;
    do_data(32'h55);
    tick(5);
    check("bp_cnt", fq.size(), 2);
    check("bp_f0", fq[0], hf(2'b01, 5'd7, 4'd2));
    check("bp_f1", fq[1], pf(2'b10, 32'h55));
    check("bp_v1", vq[1], 2'b10);
    check("bp_busy", link.busy, 0);

    // core stall between payload words
    clr();
    do_req(5'd3, 4'd4, 1'b0, 8'd2);
    do_data(32'h11);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_gap", link.out_valid, 0);
    end
    check("stall_mid", fq.size(), 2);
    @(posedge clk);
    #1;
    do_data(32'h22);
    tick(5);
    check("stall_cnt", fq.size(), 3);
    check("stall_f0", fq[0], hf(2'b01, 5'd3, 4'd4));
    check("stall_f1", fq[1], pf(2'b00, 32'h11));
    check("stall_f2", fq[2], pf(2'b10, 32'h22));

    // reset in the middle of a len=4 packet
    clr();
    do_req(5'd1, 4'd1, 1'b0, 8'd4);
    do_data(32'h1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mrst_valid", link.out_valid, 0);
    check("mrst_flit", link.out_flit, 0);
    check("mrst_req", link.req_ready, 0);
    check("mrst_dat", link.data_ready, 0);
    check("mrst_busy", link.busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    do_req(5'd6, 4'd0, 1'b0, 8'd0);
    tick(5);
    check("mrst_cnt", fq.size(), 2);
    check("mrst_f0", fq[0], hf(2'b01, 5'd1, 4'd1));
    check("mrst_f1", fq[1], hf(2'b11, 5'd6, 4'd0));

    // maximum length packet
    clr();
    do_req(5'd31, 4'd15, 1'b1, 8'd255);
    for (int i = 1; i <= 255; i++) do_data(32'(i));
    tick(5);
    nl = 0;
    foreach (fq[i]) if (fq[i][33:32] == 2'b10) nl++;
    check("max_cnt", fq.size(), 256);
    check("max_f0", fq[0], hf(2'b01, 5'd31, 4'd15));
    check("max_f1", fq[1], pf(2'b00, 32'd1));
    check("max_f254", fq[254], pf(2'b00, 32'd254));
    check("max_f255", fq[255], pf(2'b10, 32'd255));
    check("max_nlast", nl, 1);
    check("max_vld", vq[255], 2'b10);
    check("max_rem", dut.remaining, 0);
    check("max_idle", dut.state, 0);
    check("max_busy", link.busy, 0);
    check("max_rdy", link.req_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
